// File: rtl/telem_frame_tx.sv
// telem_frame_tx: captures a snapshot of N_WORDS 16-bit words on request and
// transmits it as a UART (8N1, LSB first) frame: 4 header bytes, the payload
// bytes (high byte of each word first), then an optional checksum byte.
module telem_frame_tx #(
  parameter int          N_WORDS  = 71,
  parameter int          CLK_DIV  = 54,
  parameter logic [31:0] HDR      = 32'h55AA6699,
  parameter int          CHK_EN   = 1,
  parameter int          GAP_BITS = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SNAP_EN,
  input  logic [16*N_WORDS-1:0]  SNAP_DAT,
  output logic                   TXD,
  output logic                   BUSY,
  output logic                   FRAME_DONE,
  output logic [7:0]             DROP_CNT
);

  localparam int             B         = 4 + 2 * N_WORDS + CHK_EN;
  localparam int             CW        = $clog2(B + 1);
  localparam logic [CW-1:0]  LAST_IDX  = CW'(B - 1);
  localparam logic [CW-1:0]  PAY_END   = CW'(4 + 2 * N_WORDS);
  localparam logic [15:0]    BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0]     GAP_LAST  = 4'(GAP_BITS - 1);

  // NEXT is never occupied: its decision is folded into the last STOP/GAP cycle.
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, NEXT} state_t;

  state_t          state_reg;
  logic [15:0]     baud_reg;
  logic [2:0]      bit_reg;
  logic [3:0]      gap_reg;
  logic [CW-1:0]   byte_reg;
  logic [7:0]      shift_reg;
  logic [7:0]      chk_reg;
  logic            txd_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [7:0]      drop_reg;

  logic [15:0]     snap_mem [N_WORDS];

  logic            accept;
  logic            baud_last;
  logic            advance;
  logic [CW-1:0]   nxt_idx;
  logic [CW-1:0]   pay_idx;
  logic [CW-1:0]   word_sel;
  logic [15:0]     sel_word;
  logic [7:0]      nxt_byte;
  logic            nxt_is_pay;

  assign accept    = SNAP_EN && !busy_reg && !RST;
  assign baud_last = (baud_reg == BAUD_LAST);
  assign advance   = baud_last &&
                     ((state_reg == STOP && GAP_BITS == 0) ||
                      (state_reg == GAP  && gap_reg == GAP_LAST));

  // Snapshot buffer: every word is latched in the acceptance cycle.
  generate
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_snap
      always_ff @(posedge CLK) begin
        if (accept) snap_mem[gi] <= SNAP_DAT[16*gi +: 16];
      end
    end
  endgenerate

  // Select the byte that follows the current one: header, payload or checksum.
  always_comb begin
    nxt_idx    = byte_reg + 1'b1;
    pay_idx    = nxt_idx - CW'(4);
    word_sel   = {1'b0, pay_idx[CW-1:1]};
    sel_word   = 16'h0000;
    nxt_byte   = chk_reg;
    nxt_is_pay = 1'b0;
    for (int i = 0; i < N_WORDS; i++) begin
      if (word_sel == CW'(i)) sel_word = snap_mem[i];
    end
    if (nxt_idx < CW'(4)) begin
      case (nxt_idx[1:0])
        2'd0:    nxt_byte = HDR[31:24];
        2'd1:    nxt_byte = HDR[23:16];
        2'd2:    nxt_byte = HDR[15:8];
        default: nxt_byte = HDR[7:0];
      endcase
    end else if (nxt_idx < PAY_END) begin
      nxt_byte   = pay_idx[0] ? sel_word[7:0] : sel_word[15:8];
      nxt_is_pay = 1'b1;
    end
  end

  // Frame sequencer with registered serial output and status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      gap_reg   <= '0;
      byte_reg  <= '0;
      shift_reg <= '0;
      chk_reg   <= '0;
      txd_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      drop_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      if (SNAP_EN && busy_reg && drop_reg != 8'hFF) drop_reg <= drop_reg + 8'd1;
      if (state_reg != IDLE) baud_reg <= baud_last ? 16'd0 : baud_reg + 16'd1;

      case (state_reg)
        IDLE: begin
          if (SNAP_EN) begin
            state_reg <= START;
            busy_reg  <= 1'b1;
            txd_reg   <= 1'b0;
            baud_reg  <= '0;
            byte_reg  <= '0;
            shift_reg <= HDR[31:24];
            chk_reg   <= '0;
          end
        end
        START: begin
          if (baud_last) begin
            state_reg <= DATA;
            bit_reg   <= '0;
            txd_reg   <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end
        end
        DATA: begin
          if (baud_last) begin
            if (bit_reg == 3'd7) begin
              state_reg <= STOP;
              txd_reg   <= 1'b1;
            end else begin
              bit_reg   <= bit_reg + 3'd1;
              txd_reg   <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
        end
        STOP: begin
          if (baud_last && GAP_BITS > 0) begin
            state_reg <= GAP;
            gap_reg   <= '0;
          end
        end
        GAP: begin
          if (baud_last) gap_reg <= gap_reg + 4'd1;
        end
        default: state_reg <= IDLE;
      endcase

      // End of a byte: start the next one, or close the frame.
      if (advance) begin
        if (byte_reg == LAST_IDX) begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          byte_reg  <= '0;
        end else begin
          state_reg <= START;
          txd_reg   <= 1'b0;
          byte_reg  <= nxt_idx;
          shift_reg <= nxt_byte;
          if (nxt_is_pay) chk_reg <= chk_reg + nxt_byte;
        end
      end
    end
  end

  assign TXD        = txd_reg;
  assign BUSY       = busy_reg;
  assign FRAME_DONE = done_reg;
  assign DROP_CNT   = drop_reg;

endmodule

// File: doc/telem_frame_tx.md
TELEM_FRAME_TX -- requirements
Module: telem_frame_tx

Interface
Parameters:
REQ-001 N_WORDS, 71, number of 16-bit payload words per frame; legal range 1..255.
REQ-002 CLK_DIV, 54, CLK cycles per UART bit; legal range 2..65535.
REQ-003 HDR, 32'h55AA6699, frame header, sent MSB byte first.
REQ-004 CHK_EN, 1, 1 = append an 8-bit checksum byte, 0 = no checksum byte.
REQ-005 GAP_BITS, 0, idle (mark) bit times inserted after each byte's stop bit; legal range 0..15.

Ports:
REQ-006 CLK  in  1  system clock; one clock domain; all logic on the rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 SNAP_EN  in  1  single-cycle request to capture and send a frame.
REQ-009 SNAP_DAT  in  16*N_WORDS  payload; word k = SNAP_DAT[16k+15:16k], word 0 sent first.
REQ-010 TXD  out  1  UART serial output, 8N1, LSB first, idle high.
REQ-011 BUSY  out  1  frame in progress.
REQ-012 FRAME_DONE  out  1  one-cycle pulse at frame completion.
REQ-013 DROP_CNT  out  8  count of rejected SNAP_EN requests, saturating.

Function
REQ-014 SNAP_EN is accepted only when BUSY=0 in that cycle.
REQ-015 On acceptance, all N_WORDS of SNAP_DAT are latched into an internal snapshot buffer in that cycle; later changes to SNAP_DAT do not affect the frame.
REQ-016 SNAP_EN while BUSY=1 is dropped, and DROP_CNT increments by 1, saturating at 255.
REQ-017 Frame byte order:
- HDR[31:24], HDR[23:16], HDR[15:8], HDR[7:0];
- for k = 0..N_WORDS-1: word k [15:8], then word k [7:0];
- then the checksum byte if CHK_EN=1.
REQ-018 Checksum = sum mod 256 of all payload bytes; header bytes excluded.
REQ-019 Checksum is accumulated in an 8-bit register with wrap-around; the register clears at frame acceptance.
REQ-020 State machine states: IDLE, START, DATA, STOP, GAP, NEXT.
REQ-021 State transitions:
- IDLE -> START on acceptance;
- START -> DATA after 1 bit time;
- DATA -> STOP after 8 bit times;
- STOP -> GAP after 1 bit time if GAP_BITS > 0, else STOP -> NEXT;
- GAP -> NEXT after GAP_BITS bit times;
- NEXT -> START if bytes remain, else NEXT -> IDLE.
REQ-022 One bit time = exactly CLK_DIV cycles, measured by a baud counter that restarts at each START entry.
REQ-023 NEXT lasts 0 cycles: it is folded into the final cycle of STOP/GAP, so bytes are back-to-back when GAP_BITS = 0.
REQ-024 TXD levels by state: 0 in START, data bit (LSB first) in DATA, 1 in STOP/GAP/IDLE.
REQ-025 Latency: SNAP_EN accepted in cycle t -> BUSY=1 and TXD=0 from cycle t+1.
REQ-026 Frame duration = B*(10+GAP_BITS)*CLK_DIV cycles, where B = 4 + 2*N_WORDS + CHK_EN.
REQ-027 FRAME_DONE=1 in the first cycle after the last stop/gap bit; in that same cycle BUSY=0.
REQ-028 A SNAP_EN in the FRAME_DONE cycle is accepted; the next start bit follows with no idle bit.
REQ-029 Byte and word indices use counters of width $clog2(B+1); the byte counter wraps to 0 at frame end.
REQ-030 No TXD glitches: TXD is driven from a register.

Reset
REQ-031 Output values while RST=1 and in the cycle after it is released:
- TXD=1, BUSY=0, FRAME_DONE=0, DROP_CNT=0;
- state = IDLE, all counters and the checksum = 0.
REQ-032 RST asserted mid-frame aborts the frame; TXD=1 from the next cycle.
REQ-033 No partial byte is resumed after reset.
REQ-034 Snapshot buffer contents are don't-care after reset; they are never transmitted without a new acceptance.
REQ-035 SNAP_EN during RST=1 is ignored and not counted.

Verification
REQ-036 Basic frame (N_WORDS=2, CLK_DIV=4, CHK_EN=1, GAP_BITS=0; words 0x1234, 0xABCD; one SNAP_EN):
- TXD bytes 55 AA 66 99 12 34 AB CD BE;
- BUSY high for exactly 360 cycles;
- one FRAME_DONE.
REQ-037 Snapshot isolation (same setup): change SNAP_DAT to 0x0000 one cycle after acceptance -> frame still carries 12 34 AB CD and checksum BE.
REQ-038 Drop counting (same setup): 300 SNAP_EN pulses during one frame -> DROP_CNT counts to 255, holds at 255, and no extra frame is sent.
REQ-039 Back-to-back frames: SNAP_EN in the FRAME_DONE cycle -> second frame's start bit begins the next cycle; no idle bit between frames.
REQ-040 Options (CHK_EN=0, GAP_BITS=2, N_WORDS=1, word 0x00FF):
- bytes 55 AA 66 99 00 FF;
- each byte followed by 2 mark bits;
- BUSY high for 6*12*CLK_DIV cycles.
REQ-041 Mid-frame reset: RST pulsed during the DATA bits of byte 5 -> TXD=1, BUSY=0, DROP_CNT=0 next cycle; a new SNAP_EN then sends a complete frame from HDR.
